// File: rtl/dbi_encode_4b_ac.sv
// Transmit-side DBI encoder: DC (zero-count) or AC (transition-count) inversion policy,
// single registered output stage with valid/ready, plus saturating toggle statistics.
module dbi_encode_4b_ac #(
  parameter int bw = 4,
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbi_en,
  input  logic          dbi_mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bw-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bw:0]   data_out,
  input  logic          stat_clr,
  output logic [cw-1:0] raw_toggles,
  output logic [cw-1:0] bus_toggles
);
  localparam int PW = $clog2(bw + 2);
  localparam logic [PW-1:0] BUS_W  = PW'(bw + 1);
  localparam logic [PW-1:0] RAW_W  = PW'(bw);
  localparam logic [PW-1:0] HALF_W = PW'(bw / 2);

  function automatic logic [PW-1:0] popcnt(input logic [bw:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i <= bw; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  logic [bw-1:0] raw_ref;
  logic          accept;
  logic [bw:0]   word_n, word_i, next_bus;
  logic [PW-1:0] tn, ti, zeros, raw_inc, bus_inc;
  logic          invert;
  logic [cw:0]   raw_sum, bus_sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign word_n = {1'b0, data_in};
  assign word_i = {1'b1, ~data_in};

  // AC costs are measured against the word currently on the bus; Ti + Tn is always bw+1
  assign tn    = popcnt(word_n ^ data_out);
  assign ti    = BUS_W - tn;
  assign zeros = RAW_W - popcnt(word_n);

  always_comb begin
    invert = 1'b0;
    if (dbi_en) begin
      if (dbi_mode) invert = (ti < tn);
      else          invert = (zeros > HALF_W);
    end
  end

  assign next_bus = invert ? word_i : word_n;
  assign raw_inc  = popcnt({1'b0, data_in ^ raw_ref});
  assign bus_inc  = popcnt(next_bus ^ data_out);

  // one extra bit catches the carry so the counters clamp instead of wrapping
  assign raw_sum = {1'b0, raw_toggles} + (cw + 1)'(raw_inc);
  assign bus_sum = {1'b0, bus_toggles} + (cw + 1)'(bus_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      raw_ref   <= '0;
    end else if (accept) begin
      data_out  <= next_bus;
      out_valid <= 1'b1;
      raw_ref   <= data_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      raw_toggles <= '0;
      bus_toggles <= '0;
    end else if (accept) begin
      raw_toggles <= raw_sum[cw] ? {cw{1'b1}} : raw_sum[cw-1:0];
      bus_toggles <= bus_sum[cw] ? {cw{1'b1}} : bus_sum[cw-1:0];
    end
  end
endmodule

// File: tb/tb_dbi_encode_4b_ac.sv
// Bench for dbi_encode_4b_ac: directed vector table, hand sequences and random traffic
// checked against a bit-counting reference; a cw=4 copy shares stimulus to exercise saturation.
module tb_dbi_encode_4b_ac;
  logic clk = 1'b0;
  logic reset, dbi_en, dbi_mode, in_valid, out_ready, stat_clr;
  logic [3:0] data_in;
  logic in_ready, out_valid, in_ready_s, out_valid_s;
  logic [4:0] data_out, data_out_s;
  logic [15:0] raw_toggles, bus_toggles;
  logic [3:0] raw_s, bus_s;

  always #5 clk = ~clk;

  dbi_encode_4b_ac #(.bw(4), .cw(16)) dut (
    .clk(clk), .reset(reset), .dbi_en(dbi_en), .dbi_mode(dbi_mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .stat_clr(stat_clr), .raw_toggles(raw_toggles), .bus_toggles(bus_toggles));

  dbi_encode_4b_ac #(.bw(4), .cw(4)) dut_s (
    .clk(clk), .reset(reset), .dbi_en(dbi_en), .dbi_mode(dbi_mode),
    .in_valid(in_valid), .in_ready(in_ready_s), .data_in(data_in),
    .out_valid(out_valid_s), .out_ready(out_ready), .data_out(data_out_s),
    .stat_clr(stat_clr), .raw_toggles(raw_s), .bus_toggles(bus_s));

  int n_chk = 0, n_pass = 0;

  // reference state: bus word, last raw word, unbounded toggle totals, occupancy
  logic [4:0] m_p;
  logic [3:0] m_r;
  int m_raw, m_bus;
  bit m_valid;

  function automatic int ones(input logic [4:0] v);
    int c = 0;
    for (int i = 0; i < 5; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [4:0] enc(input logic en, input logic mode,
                                     input logic [3:0] d, input logic [4:0] p);
    logic [4:0] n, iv;
    n  = {1'b0, d};
    iv = {1'b1, ~d};
    if (!en) return n;
    if (!mode) return ((4 - ones(n)) > 2) ? iv : n;
    return (ones(iv ^ p) < ones(n ^ p)) ? iv : n;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outs();
    chk("data_out", 32'(data_out), 32'(m_p));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("raw_toggles", 32'(raw_toggles), sat(m_raw, 16));
    chk("bus_toggles", 32'(bus_toggles), sat(m_bus, 16));
    chk("data_out_s", 32'(data_out_s), 32'(m_p));
    chk("raw_toggles_s", 32'(raw_s), sat(m_raw, 4));
    chk("bus_toggles_s", 32'(bus_s), sat(m_bus, 4));
  endtask

  task automatic model_reset();
    m_p = '0; m_r = '0; m_raw = 0; m_bus = 0; m_valid = 1'b0;
  endtask

  // one clock: drive, check in_ready, step the reference on the edge, check outputs
  task automatic cycle(input logic iv, input logic rdy, input logic clr,
                       input logic en, input logic mode, input logic [3:0] d);
    bit acc;
    logic [4:0] nb;
    in_valid = iv; out_ready = rdy; stat_clr = clr;
    dbi_en = en; dbi_mode = mode; data_in = d;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || rdy));
    chk("in_ready_s", 32'(in_ready_s), 32'(!m_valid || rdy));
    acc = iv && (!m_valid || rdy);
    @(posedge clk);
    if (acc) begin
      nb = enc(en, mode, d, m_p);
      m_raw += ones({1'b0, d ^ m_r});
      m_bus += ones(nb ^ m_p);
      m_p = nb; m_r = d; m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (clr) begin m_raw = 0; m_bus = 0; end
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data_out", 32'(data_out), 0);
    check_outs();
  endtask

  typedef struct {
    string      name;
    logic       mode;
    logic       en;
    logic [3:0] d;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] held;
    tbl[0] = '{"ac_f_first",  1'b1, 1'b1, 4'hF, 5'b10000};
    tbl[1] = '{"ac_f_again",  1'b1, 1'b1, 4'hF, 5'b10000};
    tbl[2] = '{"ac_zero",     1'b1, 1'b1, 4'h0, 5'b00000};
    tbl[3] = '{"ac_0011",     1'b1, 1'b1, 4'h3, 5'b00011};
    tbl[4] = '{"ac_1100",     1'b1, 1'b1, 4'hC, 5'b10011};
    tbl[5] = '{"dc_0001",     1'b0, 1'b1, 4'h1, 5'b11110};
    tbl[6] = '{"dc_0011_z2",  1'b0, 1'b1, 4'h3, 5'b00011};
    tbl[7] = '{"dc_0000",     1'b0, 1'b1, 4'h0, 5'b11111};
    tbl[8] = '{"dis_0000",    1'b0, 1'b0, 4'h0, 5'b00000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    dbi_en = 1'b1; dbi_mode = 1'b1; data_in = '0;
    @(posedge clk);
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_raw", 32'(raw_toggles), 0);

    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b1, 1'b0, tbl[i].en, tbl[i].mode, tbl[i].d);
      chk(tbl[i].name, 32'(data_out), 32'(tbl[i].exp));
      if (i == 2) begin
        chk("ac_basic_raw", 32'(raw_toggles), 8);
        chk("ac_basic_bus", 32'(bus_toggles), 2);
      end
    end

    // backpressure: stall three cycles, then release and stream back to back
    held = data_out;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
      chk("bp_hold", 32'(data_out), 32'(held));
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 0, 4'h6);

    // saturation on the narrow copy, then clear colliding with an accept
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (i % 2) ? 4'h0 : 4'hF);
    chk("raw_sat_15", 32'(raw_s), 15);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
    chk("clr_raw", 32'(raw_toggles), 0);
    chk("clr_bus", 32'(bus_toggles), 0);

    // random traffic with stalls, bubbles and occasional clears
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // reset while FULL drops the word and clears the AC reference
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF);
    chk("pre_rst_word", 32'(data_out), 32'b10000);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    in_valid = 1'b1; out_ready = 1'b0;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7);
    chk("post_rst_ac", 32'(data_out), 32'b11000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
